// File: rtl/riscv_pkg.sv
// Shared types for the pipeline memory-port arbiter.
//   XLEN        : default address/data width
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which port owns the outstanding memory slot
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between fetch (IF) and the
// memory stage (DM). One transaction is outstanding at a time; its response
// arrives MEM_LATENCY cycles after accept. Data has priority, except that
// fetch wins once it has lost STARVE_LIMIT consecutive arbitrations.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr/if_flush        fetch request, byte address, redirect
//   if_gnt/if_rvalid/if_rdata      fetch accept, response valid, data
//   dm_req/dm_we/dm_be/dm_addr/
//   dm_wdata                       data request (load/store)
//   dm_gnt/dm_rvalid/dm_rdata      data accept, response/ack valid, load data
//   mem_req/mem_we/mem_be/
//   mem_addr/mem_wdata             memory macro command (zero when idle)
//   mem_rdata                      memory read data, MEM_LATENCY after mem_req
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = riscv_pkg::XLEN,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [3:0]      dm_be,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [XLEN-1:0] dm_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             we_q,    we_d;
  logic             kill_q,  kill_d;

  logic accept_opp;
  logic resp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      cnt_q    <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      kill_q   <= kill_d;
    end
  end

  // Arbitration, memory command, response steering and next state
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    we_d      = we_q;
    kill_d    = kill_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;

    // Outputs stay quiet while reset is held
    resp       = !rst && (state_q == ARB_BUSY) && (cnt_q == '0);
    accept_opp = !rst && ((state_q == ARB_IDLE) || (cnt_q == '0));

    // Data first unless fetch is starved; a lone dm_req still wins
    if (accept_opp) begin
      if (dm_req && ((starve_q < SW'(STARVE_LIMIT)) || !if_req)) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end

    // Response for the latched owner; a flushed fetch completes silently
    if (resp) begin
      if (owner_q == OWN_IF) begin
        if_rvalid = !kill_q && !if_flush;
        if_rdata  = if_rvalid ? mem_rdata : '0;
      end else begin
        dm_rvalid = 1'b1;
        dm_rdata  = we_q ? '0 : mem_rdata;
      end
    end

    if (dm_gnt) begin
      mem_req   = 1'b1;
      mem_we    = dm_we;
      mem_be    = dm_be;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      owner_d   = OWN_DM;
      we_d      = dm_we;
      kill_d    = 1'b0;
      cnt_d     = CNT_W'(MEM_LATENCY - 1);
      state_d   = ARB_BUSY;
    end else if (if_gnt) begin
      mem_req   = 1'b1;
      mem_we    = 1'b0;
      mem_be    = 4'hF;
      mem_addr  = if_addr;
      owner_d   = OWN_IF;
      we_d      = 1'b0;
      kill_d    = if_flush;
      cnt_d     = CNT_W'(MEM_LATENCY - 1);
      state_d   = ARB_BUSY;
    end else if (resp) begin
      kill_d  = 1'b0;
      state_d = ARB_IDLE;
    end else if (state_q == ARB_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      if ((owner_q == OWN_IF) && if_flush) begin
        kill_d = 1'b1;
      end
    end

    // Count consecutive losses of a pending fetch to data
    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (dm_gnt && (starve_q < SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LATENCY 1, 2, 3) share the
// same stimulus, each with its own small memory model.
module tb_mem_port_arbiter;

  localparam int unsigned NI = 3;

  logic clk = 1'b0;
  logic rst, mem_init;
  logic if_req, if_flush, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  logic [NI-1:0]       if_gnt_v, if_rvalid_v, dm_gnt_v, dm_rvalid_v, mem_req_v, mem_we_v;
  logic [NI-1:0][31:0] if_rdata_v, dm_rdata_v, mem_addr_v, mem_wdata_v, mem_rdata_v;
  logic [NI-1:0][3:0]  mem_be_v;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w == 32'h10) ? 32'h00A00093 : (w ^ 32'hC0DE0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned ML = g + 1;

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(ML), .STARVE_LIMIT(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_gnt    (if_gnt_v[g]),
      .if_rvalid (if_rvalid_v[g]),
      .if_rdata  (if_rdata_v[g]),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_be     (dm_be),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt_v[g]),
      .dm_rvalid (dm_rvalid_v[g]),
      .dm_rdata  (dm_rdata_v[g]),
      .mem_req   (mem_req_v[g]),
      .mem_we    (mem_we_v[g]),
      .mem_be    (mem_be_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_wdata (mem_wdata_v[g]),
      .mem_rdata (mem_rdata_v[g])
    );

    // Memory model: data valid exactly ML cycles after the request, garbage otherwise
    logic [31:0] st [64];
    logic [63:0] wr;
    logic [31:0] raddr;
    int          age;

    always @(posedge clk) begin
      if (mem_init) begin
        wr    <= '0;
        age   <= 100;
        raddr <= '0;
      end else if (mem_req_v[g]) begin
        if (mem_we_v[g]) begin
          st[mem_addr_v[g][7:2]] <= merge(wr[mem_addr_v[g][7:2]] ? st[mem_addr_v[g][7:2]]
                                                                 : init_word(mem_addr_v[g]),
                                          mem_wdata_v[g], mem_be_v[g]);
          wr[mem_addr_v[g][7:2]] <= 1'b1;
        end
        raddr <= mem_addr_v[g];
        age   <= 1;
      end else if (age < 100) begin
        age <= age + 1;
      end
    end

    assign mem_rdata_v[g] = (age == int'(ML))
                          ? (wr[raddr[7:2]] ? st[raddr[7:2]] : init_word(raddr))
                          : 32'hBAD0BAD0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_quiet(input string name, input int i);
    chk({name, " if_gnt"},    32'(if_gnt_v[i]),    32'h0);
    chk({name, " dm_gnt"},    32'(dm_gnt_v[i]),    32'h0);
    chk({name, " if_rvalid"}, 32'(if_rvalid_v[i]), 32'h0);
    chk({name, " dm_rvalid"}, 32'(dm_rvalid_v[i]), 32'h0);
    chk({name, " if_rdata"},  if_rdata_v[i],       32'h0);
    chk({name, " dm_rdata"},  dm_rdata_v[i],       32'h0);
    chk({name, " mem_req"},   32'(mem_req_v[i]),   32'h0);
    chk({name, " mem_we"},    32'(mem_we_v[i]),    32'h0);
    chk({name, " mem_be"},    32'(mem_be_v[i]),    32'h0);
    chk({name, " mem_addr"},  mem_addr_v[i],       32'h0);
    chk({name, " mem_wdata"}, mem_wdata_v[i],      32'h0);
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_flush = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic if_req;
    logic dm_req;
    logic if_gnt;
    logic dm_gnt;
    logic if_rvalid;
    logic dm_rvalid;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Contention on the MEM_LATENCY=1 instance: DM x4 then IF, starve clears
    tbl[0]  = '{1, 1, 0, 1, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 0, 1};
    tbl[2]  = '{1, 1, 0, 1, 0, 1};
    tbl[3]  = '{1, 1, 0, 1, 0, 1};
    tbl[4]  = '{1, 1, 1, 0, 0, 1};
    tbl[5]  = '{1, 1, 0, 1, 1, 0};
    tbl[6]  = '{1, 1, 0, 1, 0, 1};
    tbl[7]  = '{1, 1, 0, 1, 0, 1};
    tbl[8]  = '{1, 1, 0, 1, 0, 1};
    tbl[9]  = '{1, 1, 1, 0, 0, 1};
    tbl[10] = '{1, 1, 0, 1, 1, 0};
    tbl[11] = '{0, 1, 0, 1, 0, 1};
    tbl[12] = '{1, 1, 0, 1, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 0, 1, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 1, 0};

    // Reset held with both requests active: everything quiet
    clear_inputs();
    rst = 1'b1; mem_init = 1'b1; if_req = 1'b1; dm_req = 1'b1;
    cyc(); settle();
    for (int i = 0; i < int'(NI); i++) chk_quiet($sformatf("in_reset[%0d]", i), i);
    cyc();
    clear_inputs(); rst = 1'b0; mem_init = 1'b0;
    settle();
    for (int i = 0; i < int'(NI); i++) chk_quiet($sformatf("after_reset[%0d]", i), i);

    // Lone fetch, latency 1
    cyc(); if_req = 1'b1; if_addr = 32'h10; settle();
    chk("fetch if_gnt",   32'(if_gnt_v[0]), 32'h1);
    chk("fetch dm_gnt",   32'(dm_gnt_v[0]), 32'h0);
    chk("fetch mem_addr", mem_addr_v[0],    32'h10);
    chk("fetch mem_be",   32'(mem_be_v[0]), 32'hF);
    chk("fetch mem_we",   32'(mem_we_v[0]), 32'h0);
    cyc(); if_req = 1'b0; settle();
    chk("fetch if_rvalid", 32'(if_rvalid_v[0]), 32'h1);
    chk("fetch if_rdata",  if_rdata_v[0],       32'h00A00093);
    chk("fetch dm_rvalid", 32'(dm_rvalid_v[0]), 32'h0);
    chk("fetch dm_rdata",  dm_rdata_v[0],       32'h0);
    for (int k = 0; k < 3; k++) cyc();

    // Contention table on instance 0
    do_reset();
    for (int r = 0; r < 17; r++) begin
      cyc();
      if_req = tbl[r].if_req; dm_req = tbl[r].dm_req;
      if_addr = 32'h84; dm_addr = 32'h80; dm_we = 1'b0; dm_be = 4'hF;
      settle();
      chk($sformatf("row%0d if_gnt", r),    32'(if_gnt_v[0]),    32'(tbl[r].if_gnt));
      chk($sformatf("row%0d dm_gnt", r),    32'(dm_gnt_v[0]),    32'(tbl[r].dm_gnt));
      chk($sformatf("row%0d if_rvalid", r), 32'(if_rvalid_v[0]), 32'(tbl[r].if_rvalid));
      chk($sformatf("row%0d dm_rvalid", r), 32'(dm_rvalid_v[0]), 32'(tbl[r].dm_rvalid));
      chk($sformatf("row%0d both_gnt", r),  32'(if_gnt_v[0] & dm_gnt_v[0]), 32'h0);
    end

    // Idle gap: memory command fields stay zero
    for (int k = 0; k < 5; k++) begin
      cyc(); clear_inputs(); dm_addr = 32'h80; dm_wdata = 32'h1234; settle();
      chk_quiet($sformatf("idle%0d", k), 0);
    end
    cyc(); if_req = 1'b1; dm_req = 1'b1; settle();
    chk("post_idle dm_gnt", 32'(dm_gnt_v[0]), 32'h1);
    chk("post_idle if_gnt", 32'(if_gnt_v[0]), 32'h0);

    // Fetch accepted in the same cycle as a flush is dropped
    do_reset();
    cyc(); if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h10; settle();
    chk("flush_acc if_gnt", 32'(if_gnt_v[0]), 32'h1);
    cyc(); if_req = 1'b0; if_flush = 1'b0; settle();
    chk("flush_acc if_rvalid", 32'(if_rvalid_v[0]), 32'h0);
    chk("flush_acc if_rdata",  if_rdata_v[0],       32'h0);

    // Store then load, latency 2
    do_reset();
    cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    settle();
    chk("st dm_gnt",    32'(dm_gnt_v[1]), 32'h1);
    chk("st mem_we",    32'(mem_we_v[1]), 32'h1);
    chk("st mem_wdata", mem_wdata_v[1],   32'hDEADBEEF);
    chk("st mem_addr",  mem_addr_v[1],    32'h40);
    cyc(); dm_we = 1'b0; dm_wdata = 32'h0; settle();
    chk("ld wait dm_gnt",    32'(dm_gnt_v[1]),    32'h0);
    chk("ld wait dm_rvalid", 32'(dm_rvalid_v[1]), 32'h0);
    cyc(); settle();
    chk("st ack dm_rvalid", 32'(dm_rvalid_v[1]), 32'h1);
    chk("st ack dm_rdata",  dm_rdata_v[1],       32'h0);
    chk("ld dm_gnt",        32'(dm_gnt_v[1]),    32'h1);
    chk("ld mem_we",        32'(mem_we_v[1]),    32'h0);
    cyc(); dm_req = 1'b0; settle();
    chk("ld mid dm_rvalid", 32'(dm_rvalid_v[1]), 32'h0);
    cyc(); settle();
    chk("ld dm_rvalid", 32'(dm_rvalid_v[1]), 32'h1);
    chk("ld dm_rdata",  dm_rdata_v[1],       32'hDEADBEEF);

    // Flush of an outstanding fetch, latency 3
    do_reset();
    cyc(); if_req = 1'b1; if_addr = 32'h10; settle();
    chk("fl t0 if_gnt", 32'(if_gnt_v[2]), 32'h1);
    cyc(); if_addr = 32'h20; if_flush = 1'b1; settle();
    chk("fl t1 if_gnt", 32'(if_gnt_v[2]), 32'h0);
    cyc(); if_flush = 1'b0; settle();
    chk("fl t2 if_gnt",    32'(if_gnt_v[2]),    32'h0);
    chk("fl t2 if_rvalid", 32'(if_rvalid_v[2]), 32'h0);
    cyc(); settle();
    chk("fl t3 if_rvalid", 32'(if_rvalid_v[2]), 32'h0);
    chk("fl t3 if_gnt",    32'(if_gnt_v[2]),    32'h1);
    chk("fl t3 mem_addr",  mem_addr_v[2],       32'h20);
    cyc(); if_req = 1'b0; settle();
    chk("fl t4 if_rvalid", 32'(if_rvalid_v[2]), 32'h0);
    cyc(); settle();
    chk("fl t5 if_rvalid", 32'(if_rvalid_v[2]), 32'h0);
    cyc(); settle();
    chk("fl t6 if_rvalid", 32'(if_rvalid_v[2]), 32'h1);
    chk("fl t6 if_rdata",  if_rdata_v[2],       32'hC0DE0020);

    // Reset one cycle before a load response, latency 2
    do_reset();
    cyc(); dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h40; settle();
    chk("rst ld dm_gnt", 32'(dm_gnt_v[1]), 32'h1);
    cyc(); dm_req = 1'b0; rst = 1'b1; settle();
    chk_quiet("rst held", 1);
    cyc(); rst = 1'b0; settle();
    chk_quiet("rst resp slot", 1);
    cyc(); settle();
    chk_quiet("rst after", 1);
    cyc(); dm_req = 1'b1; settle();
    chk("rst fresh dm_gnt", 32'(dm_gnt_v[1]), 32'h1);
    cyc(); dm_req = 1'b0; settle();
    chk("rst fresh mid", 32'(dm_rvalid_v[1]), 32'h0);
    cyc(); settle();
    chk("rst fresh dm_rvalid", 32'(dm_rvalid_v[1]), 32'h1);
    chk("rst fresh dm_rdata",  dm_rdata_v[1],       32'hDEADBEEF);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (MEM). It accepts at most one transaction at a time and returns each read or write acknowledgement after a fixed memory latency. Priority is data-first with a starvation guard for fetch. It sits between the IF/MEM stage logic of `PipelinedCPU` and the memory macro; the stages stall on missing grant/rvalid.

## Interface
- `XLEN`, 32, address/data width
- `MEM_LATENCY`, 1, cycles from accept to memory data valid (≥1)
- `STARVE_LIMIT`, 4, consecutive lost arbitrations after which fetch wins (≥1)

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request
- `if_addr`  in  XLEN  fetch byte address
- `if_flush`  in  1  branch redirect; drop any outstanding fetch response
- `if_gnt`  out  1  fetch accepted this cycle
- `if_rvalid`  out  1  fetch data valid
- `if_rdata`  out  XLEN  fetch data
- `dm_req`  in  1  data request
- `dm_we`  in  1  1 = store
- `dm_be`  in  4  byte enables (stores)
- `dm_addr`  in  XLEN  data byte address
- `dm_wdata`  in  XLEN  store data
- `dm_gnt`  out  1  data request accepted this cycle
- `dm_rvalid`  out  1  load data / store ack valid
- `dm_rdata`  out  XLEN  load data
- `mem_req`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_be`  out  4  memory byte enables
- `mem_addr`  out  XLEN  memory address
- `mem_wdata`  out  XLEN  memory write data
- `mem_rdata`  in  XLEN  memory read data, valid `MEM_LATENCY` cycles after `mem_req`

## Operation
- FSM states: IDLE (no outstanding), BUSY (transaction outstanding, latency counter running).
- Accept opportunity: state IDLE, or state BUSY in the response cycle (counter == 0). Back-to-back accepts give one transaction per `MEM_LATENCY` cycles.
- Arbitration at an accept opportunity: if `dm_req` and `starve_cnt < STARVE_LIMIT`, data wins; otherwise, if `if_req`, fetch wins; otherwise `dm_req` wins if set.
- Winner: `*_gnt`=1 combinationally. `mem_req`=1, and `mem_*` fields are driven from the winner (fetch forces `mem_we`=0 and `mem_be`=4'hF). Owner is latched. Counter is loaded with `MEM_LATENCY-1`. State moves to BUSY.
- No winner at an accept opportunity: state returns to IDLE. When `mem_req`=0, the `mem_*` fields are 0.
- `starve_cnt`: +1 (saturating at `STARVE_LIMIT`) when `if_req` loses to data; cleared on fetch grant or when `if_req`=0.
- Response cycle: `*_rvalid` pulses 1 cycle for the latched owner. `*_rdata` = `mem_rdata` for loads/fetches. It is 0 for stores and whenever `*_rvalid`=0.
- `if_flush`: while a fetch is outstanding (including the response cycle), `if_rvalid` is suppressed. The memory slot still completes, so there is no early re-accept. A fetch accepted in the same cycle as `if_flush` is also dropped.
- Requesters hold `req`/address/data stable until `gnt`. The arbiter never grants both ports in one cycle.

## Timing
- Reset: state IDLE, counter 0, `starve_cnt` 0, owner/flush-kill flags cleared. All outputs are 0 during and after reset until the next request.
- Reset mid-transaction: the outstanding response is discarded, and no rvalid is produced for it afterward.
- Latency: accept at cycle t → `rvalid` at cycle t+`MEM_LATENCY`.
- Simultaneous `if_req`/`dm_req` with `starve_cnt`<limit: dm granted. The (`STARVE_LIMIT`+1)th consecutive collision grants IF.
- `rvalid` and a new `gnt` may assert in the same cycle (same or different port).

## Structure
- `riscv_pkg`: `XLEN`, `arb_state_t` enum {ARB_IDLE, ARB_BUSY}, and `arb_owner_t` enum {OWN_IF, OWN_DM}.
- Single module. Latency counter, starvation counter, and priority logic stay inline; no sub-module.

## Test plan
- Lone fetch, `MEM_LATENCY`=1: `if_req`, `if_addr`=0x10, memory returns 0x00A00093. Expect `if_gnt` at t, `if_rvalid`/`if_rdata`=0x00A00093 at t+1, `dm_*` quiet.
- Store then load, `MEM_LATENCY`=2: store 0xDEADBEEF to 0x40 with `be`=4'hF, then load 0x40. Expect `dm_rvalid` at t+2 (rdata 0), load grant at t+2, `dm_rdata`=0xDEADBEEF at t+4.
- Contention with both ports continuously requesting, `STARVE_LIMIT`=4, `MEM_LATENCY`=1: grants follow DM,DM,DM,DM,IF repeating, and never both in one cycle.
- Flush: fetch accepted at t with `MEM_LATENCY`=3, `if_flush` at t+1. Expect no `if_rvalid` at t+3, and the next grant no earlier than t+3.
- Reset mid-op: load accepted, `rst` high 1 cycle before response. Expect no `dm_rvalid`, all outputs 0, and a fresh request served normally after reset.
- Idle gap: no requests for 5 cycles. Expect `mem_req`=0, `mem_*` fields 0, state IDLE, and `starve_cnt` 0.
